// File: rtl/msg_loader.sv
// Pushbutton message loader: debounces key_n and packs three 2-bit characters into a word.
// Optional sticky overrun flag enabled by defining MSG_LOADER_OVERRUN_EN.
module msg_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       key_n,
    input  logic [1:0] char_in,
    input  logic       word_ack,
    output logic [5:0] word,
    output logic       word_valid,
    output logic [1:0] char_count,
    output logic       overrun
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FULL
    } state_t;

    logic [1:0]       sync;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             press_c;

    state_t     state, state_nx;
    logic [5:0] word_nx;
    logic [1:0] count_nx;

    // Synchronizer and debouncer; stable level follows input after a full run of mismatches
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync   <= 2'b11;
            stable <= 1'b1;
            cnt    <= '0;
        end else begin
            sync <= {sync[0], key_n};
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Press event fires in the cycle the stable level is about to fall
    assign press_c = stable & ~sync[1] & (cnt == CNT_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            word       <= '0;
            word_valid <= 1'b0;
            char_count <= '0;
        end else begin
            state      <= state_nx;
            word       <= word_nx;
            word_valid <= (state_nx == FULL);
            char_count <= count_nx;
        end
    end

    always_comb begin
        state_nx = state;
        word_nx  = word;
        count_nx = char_count;
        unique case (state)
            IDLE: begin
                if (press_c) begin
                    word_nx  = {char_in, 4'b0000};
                    count_nx = 2'd1;
                    state_nx = FILL;
                end
            end
            FILL: begin
                if (press_c) begin
                    if (char_count == 2'd1) begin
                        word_nx[3:2] = char_in;
                        count_nx     = 2'd2;
                    end else begin
                        word_nx[1:0] = char_in;
                        count_nx     = 2'd3;
                        state_nx     = FULL;
                    end
                end
            end
            FULL: begin
                // Ack releases the word; a coincident press starts the next word
                if (word_ack) begin
                    if (press_c) begin
                        word_nx  = {char_in, 4'b0000};
                        count_nx = 2'd1;
                        state_nx = FILL;
                    end else begin
                        count_nx = 2'd0;
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                word_nx  = '0;
                count_nx = '0;
            end
        endcase
    end

`ifdef MSG_LOADER_OVERRUN_EN
    logic drop_c;

    assign drop_c = (state == FULL) & press_c & ~word_ack;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop_c) begin
            overrun <= 1'b1;
        end
    end
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: doc/msg_loader.md
MSG_LOADER -- requirements
Module: msg_loader

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key_n level change (10 ms at 50 MHz).
REQ-002 CLOCK_50  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 key_n  input  1  raw pushbutton, active-low, asynchronous to CLOCK_50, bouncy.
REQ-005 char_in  input  2  character code from switches, sampled on an accepted press.
REQ-006 word_ack  input  1  downstream scroller consumed word; one-cycle pulse.
REQ-007 word  output  6  packed 3-character message; first char in [5:4], second in [3:2], third in [1:0].
REQ-008 word_valid  output  1  word complete and stable; held until acknowledged.
REQ-009 char_count  output  2  characters captured in the current word, 0..3.
REQ-010 overrun  output  1  sticky flag: a press was dropped while the word was full.

Function
REQ-011 key_n SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Debouncer SHALL hold a stable level and a counter; the counter clears on any mismatch between synchronized input and stable level.
REQ-013 Stable level SHALL change only after DEBOUNCE_CYCLES consecutive cycles of mismatch.
REQ-014 An accepted press SHALL be a 1-cycle internal pulse on the stable level's 1->0 transition; releases generate no event.
REQ-015 FSM states SHALL be IDLE (char_count=0), FILL (char_count 1..2), FULL (char_count=3, word_valid=1).
REQ-016 IDLE/FILL press: char_in written to slot char_count, char_count increments in the same edge; pulse with char_count=2 moves to FULL.
REQ-017 IDLE press SHALL also clear word to 6'b000000 before capture into [5:4].
REQ-018 word_valid SHALL assert the cycle after the third character is captured (1-cycle latency from press pulse).
REQ-019 In FULL, word and word_valid SHALL stay constant until word_ack.
REQ-020 FULL + word_ack: next state IDLE, word_valid=0, char_count=0, word retains its value.
REQ-021 FULL + press without word_ack: press dropped, word unchanged, overrun set per REQ-029.
REQ-022 FULL + word_ack + press same cycle: ack honoured and char_in captured as first char of the new word (state FILL, char_count=1, word={char_in,4'b0000}).
REQ-023 word_ack outside FULL SHALL be ignored.
REQ-024 char_in SHALL be sampled only in the press-pulse cycle; changes at other times have no effect.

Reset
REQ-025 reset SHALL force state IDLE, word=0, word_valid=0, char_count=0, overrun=0.
REQ-026 reset SHALL set the debouncer stable level to 1 (released), counter 0, synchronizer flops to 1.
REQ-027 reset mid-word or mid-debounce SHALL discard all partial state; no press event for at least DEBOUNCE_CYCLES cycles afterwards.
REQ-028 Reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-029 With macro MSG_LOADER_OVERRUN_EN defined: overrun sets on a dropped press (REQ-021) and clears only on reset.
REQ-030 Without MSG_LOADER_OVERRUN_EN: overrun tied to 0, no overrun logic instantiated; all other behaviour identical.

Verification (DEBOUNCE_CYCLES=4 for simulation)
REQ-031 key_n low 3 cycles then high, bouncing -> no capture, char_count stays 0.
REQ-032 Three clean presses with char_in=01,10,11 -> word=6'b011011, word_valid=1 one cycle after third press pulse, char_count=3.
REQ-033 FULL, fourth press char_in=00, no ack -> word stays 6'b011011; overrun=1 with macro, 0 without.
REQ-034 FULL, word_ack and press char_in=10 same cycle -> word_valid=0, char_count=1, word=6'b100000.
REQ-035 reset asserted after two captured chars -> char_count=0, word=0, word_valid=0, overrun=0 next cycle; held-low key_n produces no capture until 4 stable cycles after reset deasserts.
